// File: rtl/can_sim_pkg.sv
// Shared definitions for the clocked CAN bus model: bus levels, the glitch
// FSM state type and a delay clamp helper used by the per-node delay lines.
package can_sim_pkg;

  localparam logic CAN_DOMINANT  = 1'b0;
  localparam logic CAN_RECESSIVE = 1'b1;

  typedef enum logic {
    GL_IDLE   = 1'b0,
    GL_ACTIVE = 1'b1
  } glitch_state_t;

  // Requested delays beyond the physical depth read the deepest tap.
  function automatic int clamp_delay(input int d, input int max_d);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/can_sim_delay_line.sv
// One node's propagation delay: a MAX_DELAY-deep shift register that is
// refilled recessive on reset, plus a tap mux. A delay of 0 passes the input
// straight through; delay d reads the sample taken d clocks ago.
module can_sim_delay_line
  import can_sim_pkg::*;
#(
  parameter int MAX_DELAY = 16,
  parameter int DW        = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          din_i,
  input  logic [DW-1:0] delay_i,
  output logic          dout_o
);

  logic [MAX_DELAY-1:0] r_sr;
  int                   w_eff_delay;

  // Shift the node level in every cycle; reset refills with recessive.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sr <= {MAX_DELAY{CAN_RECESSIVE}};
    end else begin
      r_sr[0] <= din_i;
      for (int k = 1; k < MAX_DELAY; k++) begin
        r_sr[k] <= r_sr[k-1];
      end
    end
  end

  // Clamp the requested delay and pick the matching tap (0 = bypass).
  always_comb begin
    w_eff_delay = clamp_delay(int'(delay_i), MAX_DELAY);
    dout_o      = din_i;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (w_eff_delay == k + 1) dout_o = r_sr[k];
    end
  end

endmodule

// File: rtl/can_bus_sim_clocked.sv
// Clocked CAN bus model for system benches. Node tx lines merge as a
// wired-AND (0 dominant). Each node's contribution to the other nodes' rx is
// delayed by its own delay line; a node always sees its own tx undelayed.
// Extras: node disconnect, forced-dominant fault, a timed rx glitch on one
// node, and a monitor counting stuck-dominant cycles and SOF-like edges.
//
// Glitch request handshake: glitch_start_i is a single-cycle pulse, sampled
// only while the FSM is idle; it is accepted when glitch_len_i is non-zero and
// glitch_node_i names an existing node, otherwise it is dropped. While a
// glitch runs glitch_busy_o is high and further starts are ignored.
module can_bus_sim_clocked
  import can_sim_pkg::*;
#(
  parameter int N           = 2,
  parameter int MAX_DELAY   = 16,
  parameter int DW          = 5,
  parameter int CNT_W       = 16,
  parameter int STUCK_LIMIT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         tx_i,
  output logic [N-1:0]         rx_o,
  input  logic [N-1:0]         node_en_i,
  input  logic [N*DW-1:0]      delay_i,
  input  logic                 force_dom_i,
  input  logic                 glitch_start_i,
  input  logic [$clog2(N)-1:0] glitch_node_i,
  input  logic [7:0]           glitch_len_i,
  output logic                 glitch_busy_o,
  output logic                 bus_o,
  output logic                 stuck_o,
  output logic [CNT_W-1:0]     edge_cnt_o
);

  localparam int NW = $clog2(N);
  localparam int SW = $clog2(STUCK_LIMIT + 1);

  logic [N-1:0]  w_eff_tx;
  logic [N-1:0]  w_dtx;
  logic [N-1:0]  w_glitch;
  logic          w_bus;
  logic          w_node_ok;

  glitch_state_t r_state, w_state_nxt;
  logic [7:0]    r_gl_cnt, w_gl_cnt_nxt;
  logic [NW-1:0] r_gl_node, w_gl_node_nxt;

  logic [SW-1:0]    r_stuck_cnt, w_stuck_nxt;
  logic             r_stuck;
  logic             r_bus_q;
  logic [CNT_W-1:0] r_edge_cnt;

  // A disconnected node contributes recessive to the bus.
  assign w_eff_tx = tx_i | ~node_en_i;
  assign w_bus    = &w_eff_tx;
  assign bus_o    = w_bus;

  // Per-node propagation delay toward the other nodes.
  for (genvar t = 0; t < N; t++) begin : g_dly
    can_sim_delay_line #(
      .MAX_DELAY (MAX_DELAY),
      .DW        (DW)
    ) u_dly (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .din_i   (w_eff_tx[t]),
      .delay_i (delay_i[t*DW +: DW]),
      .dout_o  (w_dtx[t])
    );
  end

  // Receive path per node: own tx undelayed, others delayed, then force and
  // glitch; a disconnected node reads recessive regardless.
  for (genvar r = 0; r < N; r++) begin : g_rx
    logic w_others;
    always_comb begin
      w_others = CAN_RECESSIVE;
      for (int t = 0; t < N; t++) begin
        if (t != r) w_others = w_others & w_dtx[t];
      end
      if (node_en_i[r]) begin
        rx_o[r] = (w_eff_tx[r] & w_others & ~force_dom_i) ^ w_glitch[r];
      end else begin
        rx_o[r] = CAN_RECESSIVE;
      end
    end
  end

  assign w_node_ok = (int'(glitch_node_i) < N);

  // Glitch FSM state, length counter and target node registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= GL_IDLE;
      r_gl_cnt  <= '0;
      r_gl_node <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gl_cnt  <= w_gl_cnt_nxt;
      r_gl_node <= w_gl_node_nxt;
    end
  end

  // Glitch FSM next state: the counter starts at len and the FSM leaves
  // ACTIVE on the cycle it holds 1, so the glitch lasts exactly len cycles.
  always_comb begin
    w_state_nxt   = r_state;
    w_gl_cnt_nxt  = r_gl_cnt;
    w_gl_node_nxt = r_gl_node;
    case (r_state)
      GL_IDLE: begin
        if (glitch_start_i && (glitch_len_i != 8'd0) && w_node_ok) begin
          w_state_nxt   = GL_ACTIVE;
          w_gl_cnt_nxt  = glitch_len_i;
          w_gl_node_nxt = glitch_node_i;
        end
      end
      GL_ACTIVE: begin
        w_gl_cnt_nxt = r_gl_cnt - 8'd1;
        if (r_gl_cnt == 8'd1) w_state_nxt = GL_IDLE;
      end
      default: begin
        w_state_nxt = GL_IDLE;
      end
    endcase
  end

  // Glitch mask decoded from registered state so reset removes it at once.
  always_comb begin
    w_glitch = '0;
    if (r_state == GL_ACTIVE) begin
      for (int t = 0; t < N; t++) begin
        if (int'(r_gl_node) == t) w_glitch[t] = 1'b1;
      end
    end
  end

  assign glitch_busy_o = (r_state == GL_ACTIVE);

  // Consecutive-dominant run length, saturating at the stuck limit.
  always_comb begin
    w_stuck_nxt = r_stuck_cnt;
    if (w_bus == CAN_RECESSIVE) begin
      w_stuck_nxt = '0;
    end else if (r_stuck_cnt != SW'(STUCK_LIMIT)) begin
      w_stuck_nxt = r_stuck_cnt + SW'(1);
    end
  end

  // Stuck counter and its registered flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stuck_cnt <= '0;
      r_stuck     <= 1'b0;
    end else begin
      r_stuck_cnt <= w_stuck_nxt;
      r_stuck     <= (w_stuck_nxt == SW'(STUCK_LIMIT));
    end
  end

  assign stuck_o = r_stuck;

  // Count recessive-to-dominant bus edges; the counter wraps naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bus_q    <= CAN_RECESSIVE;
      r_edge_cnt <= '0;
    end else begin
      r_bus_q <= w_bus;
      if (r_bus_q == CAN_RECESSIVE && w_bus == CAN_DOMINANT) begin
        r_edge_cnt <= r_edge_cnt + CNT_W'(1);
      end
    end
  end

  assign edge_cnt_o = r_edge_cnt;

endmodule

// File: tb/tb_can_bus_sim_clocked.sv
// Bench for can_bus_sim_clocked with N=3. A reference model keeps a history
// queue of merged node levels, a glitch countdown, a dominant run length and
// an edge tally; every cycle all DUT outputs are compared against it.
module tb_can_bus_sim_clocked;

  localparam int N           = 3;
  localparam int MAX_DELAY   = 16;
  localparam int DW          = 5;
  localparam int CNT_W       = 16;
  localparam int STUCK_LIMIT = 64;
  localparam int GW          = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      tx, en, rx;
  logic [N*DW-1:0]   dly;
  logic              f_dom, gstart, busy, bus, stuck;
  logic [GW-1:0]     gnode;
  logic [7:0]        glen;
  logic [CNT_W-1:0]  ecnt;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [N-1:0] m_past[$];   // m_past[k] = node levels k+1 cycles ago
  int           m_gl_left;
  int           m_gl_node;
  int           m_dom_run;
  int           m_edges;
  logic         m_prev_bus;

  can_bus_sim_clocked #(
    .N(N), .MAX_DELAY(MAX_DELAY), .DW(DW), .CNT_W(CNT_W), .STUCK_LIMIT(STUCK_LIMIT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tx_i           (tx),
    .rx_o           (rx),
    .node_en_i      (en),
    .delay_i        (dly),
    .force_dom_i    (f_dom),
    .glitch_start_i (gstart),
    .glitch_node_i  (gnode),
    .glitch_len_i   (glen),
    .glitch_busy_o  (busy),
    .bus_o          (bus),
    .stuck_o        (stuck),
    .edge_cnt_o     (ecnt)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_eff();
    return tx | ~en;
  endfunction

  function automatic logic m_dtx(input int t);
    int           d;
    logic [N-1:0] e;
    logic [N-1:0] p;
    d = int'(dly[t*DW +: DW]);
    if (d > MAX_DELAY) d = MAX_DELAY;
    e = m_eff();
    if (d == 0) return e[t];
    p = m_past[d-1];
    return p[t];
  endfunction

  function automatic logic [N-1:0] m_rx();
    logic [N-1:0] e;
    logic [N-1:0] res;
    logic         v;
    e = m_eff();
    for (int r = 0; r < N; r++) begin
      if (!en[r]) begin
        res[r] = 1'b1;
      end else begin
        v = e[r] & ~f_dom;
        for (int t = 0; t < N; t++) if (t != r) v = v & m_dtx(t);
        if (m_gl_left > 0 && m_gl_node == r) v = ~v;
        res[r] = v;
      end
    end
    return res;
  endfunction

  task automatic model_reset();
    m_past.delete();
    repeat (MAX_DELAY) m_past.push_back('1);
    m_gl_left  = 0;
    m_gl_node  = 0;
    m_dom_run  = 0;
    m_edges    = 0;
    m_prev_bus = 1'b1;
  endtask

  task automatic model_clock();
    logic [N-1:0] e;
    logic         b;
    e = m_eff();
    b = &e;
    if (m_gl_left > 0) m_gl_left--;
    else if (gstart && glen != 8'd0 && int'(gnode) < N) begin
      m_gl_left = int'(glen);
      m_gl_node = int'(gnode);
    end
    m_dom_run = b ? 0 : m_dom_run + 1;
    if (m_prev_bus && !b) m_edges++;
    m_prev_bus = b;
    m_past.push_front(e);
    void'(m_past.pop_back());
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] e;
    e = m_eff();
    check_eq({tag, ":rx"},    32'(rx),    32'(m_rx()));
    check_eq({tag, ":bus"},   32'(bus),   32'(&e));
    check_eq({tag, ":busy"},  32'(busy),  32'(m_gl_left > 0));
    check_eq({tag, ":stuck"}, 32'(stuck), 32'(m_dom_run >= STUCK_LIMIT));
    check_eq({tag, ":edges"}, 32'(ecnt),  32'(m_edges % (1 << CNT_W)));
  endtask

  // One cycle: inputs already driven after the falling edge; compare, clock.
  task automatic cyc(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    if (rst) model_reset();
    else model_clock();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    tx = '1; en = '1; dly = '0; f_dom = 1'b0;
    gstart = 1'b0; gnode = '0; glen = 8'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cyc("rst");
    cyc("rst");
    rst = 1'b0;
  endtask

  initial begin
    int low_cnt;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    check_eq("reset_busy",  32'(busy), 32'd0);
    check_eq("reset_stuck", 32'(stuck), 32'd0);
    check_eq("reset_edges", 32'(ecnt), 32'd0);
    check_eq("reset_rx",    32'(rx), 32'h7);
    @(negedge clk);
    rst = 1'b0;

    // Plain wired-AND with no delays.
    tx = 3'b110;
    #1;
    check_eq("and_rx",  32'(rx), 32'h0);
    check_eq("and_bus", 32'(bus), 32'd0);
    cyc("t1");
    check_eq("and_edge", 32'(ecnt), 32'd1);
    tx = '1;
    cyc("t1b");

    // Node 1 delayed by 4 cycles; a 1-cycle dominant pulse.
    dly = {5'd0, 5'd4, 5'd0};
    repeat (4) cyc("t2pre");
    tx = 3'b101;
    #1;
    check_eq("dly_own", 32'(rx[1]), 32'd0);
    cyc("t2p");
    tx = '1;
    cyc("t2a"); cyc("t2b");
    #1;
    check_eq("dly_before", 32'(rx), 32'h7);
    cyc("t2c");
    #1;
    check_eq("dly_arrive", 32'(rx), 32'h2);
    cyc("t2d");
    #1;
    check_eq("dly_after", 32'(rx), 32'h7);
    dly = '0;
    repeat (MAX_DELAY) cyc("t2flush");

    // Disconnected node and forced dominant.
    en = 3'b101; tx = 3'b101;
    #1;
    check_eq("dis_bus", 32'(bus), 32'd1);
    f_dom = 1'b1;
    #1;
    check_eq("dis_rx1", 32'(rx[1]), 32'd1);
    check_eq("force_rx0", 32'(rx[0]), 32'd0);
    cyc("t3");
    idle_inputs();
    cyc("t3b");

    // Glitch on node 2 for 5 cycles; a second start is ignored.
    gnode = 2'd2; glen = 8'd5; gstart = 1'b1;
    cyc("t4s");
    gnode = 2'd0; glen = 8'd9;
    low_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (rx[2] == 1'b0) low_cnt++;
      cyc("t4");
      gstart = 1'b0;
    end
    check_eq("glitch_len", 32'(low_cnt), 32'd5);
    // Zero length and out-of-range node are dropped.
    gstart = 1'b1; glen = 8'd0; gnode = 2'd1;
    cyc("t4z");
    glen = 8'd4; gnode = 2'd3;
    cyc("t4o");
    gstart = 1'b0;
    #1;
    check_eq("glitch_ignored", 32'(busy), 32'd0);
    cyc("t4e");

    // Stuck dominant.
    tx = 3'b110;
    repeat (STUCK_LIMIT - 1) cyc("t5");
    #1;
    check_eq("stuck_pre", 32'(stuck), 32'd0);
    cyc("t5");
    #1;
    check_eq("stuck_hit", 32'(stuck), 32'd1);
    repeat (6) cyc("t5h");
    tx = '1;
    cyc("t5r");
    #1;
    check_eq("stuck_clear", 32'(stuck), 32'd0);

    // Reset mid-glitch with a delayed dominant in flight.
    dly = {5'd0, 5'd6, 5'd0};
    tx = 3'b101;
    cyc("t6p");
    tx = '1; gstart = 1'b1; gnode = 2'd0; glen = 8'd8;
    cyc("t6s");
    gstart = 1'b0;
    cyc("t6a");
    rst = 1'b1;
    #1;
    check_eq("rst_rx",    32'(rx), 32'(tx));
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_edges", 32'(ecnt), 32'd0);
    check_eq("rst_stuck", 32'(stuck), 32'd0);
    model_reset();
    cyc("t6r");
    rst = 1'b0;
    cyc("t6x");

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < N; b++) tx[b] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) en = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      if ($urandom_range(0, 15) == 0) begin
        for (int b = 0; b < N; b++) dly[b*DW +: DW] = DW'($urandom_range(0, 20));
      end
      f_dom  = ($urandom_range(0, 19) == 0);
      gstart = ($urandom_range(0, 9) == 0);
      gnode  = GW'($urandom_range(0, 3));
      glen   = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
